// File: rtl/mem_arbiter.sv
// Arbitrates the single data-memory port between the pipeline MEM stage and the
// debug/loader port. A starved debug request is forced through after MAX_WAIT denials.
module mem_arbiter #(
    parameter int D_SIZE        = 32,
    parameter int ADDR_LINE_MEM = 10,
    parameter int MAX_WAIT      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pipe_req,
    input  logic                     pipe_we,
    input  logic [ADDR_LINE_MEM-1:0] pipe_addr,
    input  logic [D_SIZE-1:0]        pipe_wdata,
    output logic                     pipe_stall,
    output logic                     pipe_rvalid,
    output logic [D_SIZE-1:0]        pipe_rdata,
    input  logic                     dbg_req,
    input  logic                     dbg_we,
    input  logic [ADDR_LINE_MEM-1:0] dbg_addr,
    input  logic [D_SIZE-1:0]        dbg_wdata,
    input  logic                     dbg_halt,
    output logic                     dbg_ack,
    output logic                     dbg_rvalid,
    output logic [D_SIZE-1:0]        dbg_rdata,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_LINE_MEM-1:0] mem_addr,
    output logic [D_SIZE-1:0]        mem_wdata,
    input  logic [D_SIZE-1:0]        mem_rdata
);

    typedef enum logic [1:0] {
        NORMAL,
        FORCE,
        HALTED
    } state_t;

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    state_t              r_state;
    logic [3:0]          r_waitCnt;
    logic                r_pipeRd;
    logic                r_dbgRd;
    logic [D_SIZE-1:0]   r_pipeHold;
    logic [D_SIZE-1:0]   r_dbgHold;

    logic                w_pipeGrant;
    logic                w_dbgGrant;
    logic [3:0]          w_cntInc;

    assign w_cntInc = r_waitCnt + 4'd1;

    // Reset gates every grant so nothing reaches memory while reset is held,
    // even in the first reset cycle before the state registers have cleared.
    always_comb begin
        w_pipeGrant = 1'b0;
        w_dbgGrant  = 1'b0;
        pipe_stall  = 1'b0;
        if (!reset) begin
            case (r_state)
                NORMAL: begin
                    w_pipeGrant = pipe_req;
                    w_dbgGrant  = dbg_req && !pipe_req;
                end
                FORCE, HALTED: begin
                    w_dbgGrant = dbg_req;
                    pipe_stall = pipe_req;
                end
                default: ;
            endcase
        end
    end

    assign dbg_ack   = w_dbgGrant;
    assign mem_en    = w_pipeGrant || w_dbgGrant;
    assign mem_we    = w_dbgGrant ? dbg_we    : (w_pipeGrant && pipe_we);
    assign mem_addr  = w_dbgGrant ? dbg_addr  : pipe_addr;
    assign mem_wdata = w_dbgGrant ? dbg_wdata : pipe_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= NORMAL;
            r_waitCnt  <= 4'd0;
            r_pipeRd   <= 1'b0;
            r_dbgRd    <= 1'b0;
            r_pipeHold <= '0;
            r_dbgHold  <= '0;
        end else begin
            r_pipeRd <= w_pipeGrant && !pipe_we;
            r_dbgRd  <= w_dbgGrant && !dbg_we;
            if (r_pipeRd) r_pipeHold <= mem_rdata;
            if (r_dbgRd)  r_dbgHold  <= mem_rdata;

            if (dbg_halt) begin
                r_state   <= HALTED;
                r_waitCnt <= 4'd0;
            end else begin
                case (r_state)
                    NORMAL: begin
                        if (dbg_req && !w_dbgGrant) begin
                            r_waitCnt <= w_cntInc;
                            if (w_cntInc == MAX_WAIT_C) r_state <= FORCE;
                        end else begin
                            r_waitCnt <= 4'd0;
                        end
                    end
                    default: begin
                        r_state   <= NORMAL;
                        r_waitCnt <= 4'd0;
                    end
                endcase
            end
        end
    end

    // Read data passes straight through on the return cycle and is held afterwards.
    assign pipe_rvalid = r_pipeRd && !reset;
    assign dbg_rvalid  = r_dbgRd && !reset;
    assign pipe_rdata  = reset ? '0 : (r_pipeRd ? mem_rdata : r_pipeHold);
    assign dbg_rdata   = reset ? '0 : (r_dbgRd  ? mem_rdata : r_dbgHold);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with MAX_WAIT=4; inputs change on the
// falling edge and outputs are checked 1 ns later.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_req, pipe_we;
    logic [9:0]  pipe_addr;
    logic [31:0] pipe_wdata;
    logic        pipe_stall, pipe_rvalid;
    logic [31:0] pipe_rdata;
    logic        dbg_req, dbg_we;
    logic [9:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_halt;
    logic        dbg_ack, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checkCount = 0;
    int failCount  = 0;

    mem_arbiter #(
        .D_SIZE(32),
        .ADDR_LINE_MEM(10),
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pipe_req(pipe_req),
        .pipe_we(pipe_we),
        .pipe_addr(pipe_addr),
        .pipe_wdata(pipe_wdata),
        .pipe_stall(pipe_stall),
        .pipe_rvalid(pipe_rvalid),
        .pipe_rdata(pipe_rdata),
        .dbg_req(dbg_req),
        .dbg_we(dbg_we),
        .dbg_addr(dbg_addr),
        .dbg_wdata(dbg_wdata),
        .dbg_halt(dbg_halt),
        .dbg_ack(dbg_ack),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata(dbg_rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs at the falling edge, then waits 1 ns so checks
    // see settled combinational and registered outputs.
    task automatic applyStimulus(input logic rst, input logic preq, input logic pwe,
                                 input logic [9:0] paddr, input logic [31:0] pwdata,
                                 input logic dreq, input logic dwe, input logic [9:0] daddr,
                                 input logic [31:0] dwdata, input logic dhalt,
                                 input logic [31:0] mrdata);
        @(negedge clk);
        reset      = rst;
        pipe_req   = preq;
        pipe_we    = pwe;
        pipe_addr  = paddr;
        pipe_wdata = pwdata;
        dbg_req    = dreq;
        dbg_we     = dwe;
        dbg_addr   = daddr;
        dbg_wdata  = dwdata;
        dbg_halt   = dhalt;
        mem_rdata  = mrdata;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        reset = 1'b1; pipe_req = 0; pipe_we = 0; pipe_addr = 0; pipe_wdata = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0; dbg_halt = 0; mem_rdata = 0;

        // Reset held with both requesters active: nothing may be granted.
        applyStimulus(1, 1, 0, 10'h010, 0, 1, 0, 10'h020, 0, 0, 32'h0);
        applyStimulus(1, 1, 0, 10'h010, 0, 1, 0, 10'h020, 0, 0, 32'h0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_dbg_ack", dbg_ack, 0);
        checkOutput("rst_pipe_stall", pipe_stall, 0);
        checkOutput("rst_pipe_rvalid", pipe_rvalid, 0);
        checkOutput("rst_dbg_rvalid", dbg_rvalid, 0);
        checkOutput("rst_pipe_rdata", pipe_rdata, 0);
        checkOutput("rst_dbg_rdata", dbg_rdata, 0);

        // Pipeline read granted in the very first cycle out of reset.
        applyStimulus(0, 1, 0, 10'h010, 0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("rd_mem_en", mem_en, 1);
        checkOutput("rd_mem_we", mem_we, 0);
        checkOutput("rd_mem_addr", mem_addr, 32'h010);
        checkOutput("rd_pipe_stall", pipe_stall, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        checkOutput("rd_pipe_rvalid", pipe_rvalid, 1);
        checkOutput("rd_pipe_rdata", pipe_rdata, 32'hDEADBEEF);
        checkOutput("rd_dbg_rvalid", dbg_rvalid, 0);
        checkOutput("rd_idle_mem_en", mem_en, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("rd_rvalid_drop", pipe_rvalid, 0);
        checkOutput("rd_rdata_hold", pipe_rdata, 32'hDEADBEEF);

        // Starvation: pipe writes win four times, then the debug read is forced.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 10'h020, 32'hA5, 1, 0, 10'h030, 0, 0, 32'h0);
            checkOutput("starve_dbg_ack", dbg_ack, 0);
            checkOutput("starve_pipe_stall", pipe_stall, 0);
            checkOutput("starve_mem_addr", mem_addr, 32'h020);
            checkOutput("starve_mem_we", mem_we, 1);
            checkOutput("starve_wdata", mem_wdata, 32'hA5);
        end
        applyStimulus(0, 1, 1, 10'h020, 32'hA5, 1, 0, 10'h030, 0, 0, 32'h0);
        checkOutput("force_dbg_ack", dbg_ack, 1);
        checkOutput("force_pipe_stall", pipe_stall, 1);
        checkOutput("force_mem_addr", mem_addr, 32'h030);
        checkOutput("force_mem_we", mem_we, 0);
        checkOutput("write_no_rvalid", pipe_rvalid, 0);
        applyStimulus(0, 1, 1, 10'h020, 32'hA5, 1, 0, 10'h030, 0, 0, 32'hCAFEF00D);
        checkOutput("after_force_stall", pipe_stall, 0);
        checkOutput("after_force_ack", dbg_ack, 0);
        checkOutput("after_force_addr", mem_addr, 32'h020);
        checkOutput("force_dbg_rvalid", dbg_rvalid, 1);
        checkOutput("force_dbg_rdata", dbg_rdata, 32'hCAFEF00D);
        checkOutput("force_no_pipe_rvalid", pipe_rvalid, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("idle_dbg_rvalid", dbg_rvalid, 0);
        checkOutput("idle_pipe_rvalid", pipe_rvalid, 0);

        // Reach FORCE again, then drop the debug request inside FORCE.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 10'h021, 32'h1, 1, 1, 10'h031, 32'h2, 0, 32'h0);
        end
        applyStimulus(0, 1, 1, 10'h021, 32'h1, 0, 1, 10'h031, 32'h2, 0, 32'h0);
        checkOutput("drop_mem_en", mem_en, 0);
        checkOutput("drop_pipe_stall", pipe_stall, 1);
        checkOutput("drop_dbg_ack", dbg_ack, 0);
        // A cleared wait counter means four more denials before the next force.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, 10'h021, 32'h1, 1, 1, 10'h031, 32'h2, 0, 32'h0);
            checkOutput("drop_normal_stall", pipe_stall, 0);
            checkOutput("drop_normal_ack", dbg_ack, 0);
        end
        applyStimulus(0, 1, 1, 10'h021, 32'h1, 1, 1, 10'h031, 32'h2, 0, 32'h0);
        checkOutput("drop_reforce_ack", dbg_ack, 1);
        checkOutput("drop_reforce_wdata", mem_wdata, 32'h2);

        // Halt: first cycle still NORMAL, then the debug port owns memory.
        applyStimulus(0, 1, 0, 10'h040, 0, 0, 0, 0, 0, 1, 32'h0);
        checkOutput("halt_entry_stall", pipe_stall, 0);
        checkOutput("halt_entry_en", mem_en, 1);
        applyStimulus(0, 1, 0, 10'h040, 0, 1, 1, 10'h3FF, 32'h12345678, 1, 32'h11112222);
        checkOutput("halt_pipe_stall", pipe_stall, 1);
        checkOutput("halt_dbg_ack", dbg_ack, 1);
        checkOutput("halt_mem_we", mem_we, 1);
        checkOutput("halt_mem_addr", mem_addr, 32'h3FF);
        checkOutput("halt_mem_wdata", mem_wdata, 32'h12345678);
        checkOutput("halt_pipe_rvalid", pipe_rvalid, 1);
        checkOutput("halt_pipe_rdata", pipe_rdata, 32'h11112222);
        applyStimulus(0, 1, 0, 10'h040, 0, 0, 1, 10'h3FF, 32'h12345678, 1, 32'h0);
        checkOutput("halt2_stall", pipe_stall, 1);
        checkOutput("halt2_ack", dbg_ack, 0);
        checkOutput("halt2_mem_en", mem_en, 0);
        applyStimulus(0, 1, 0, 10'h040, 0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("unhalt_stall", pipe_stall, 1);
        applyStimulus(0, 1, 0, 10'h040, 0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("resume_stall", pipe_stall, 0);
        checkOutput("resume_mem_en", mem_en, 1);

        // Alternating pipe/dbg reads: returns follow their owners one cycle later.
        applyStimulus(0, 1, 0, 10'h050, 0, 0, 0, 0, 0, 0, 32'h40404040);
        checkOutput("alt1_pipe_rvalid", pipe_rvalid, 1);
        checkOutput("alt1_pipe_rdata", pipe_rdata, 32'h40404040);
        checkOutput("alt1_mem_addr", mem_addr, 32'h050);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, 10'h060, 0, 0, 32'h50505050);
        checkOutput("alt2_pipe_rvalid", pipe_rvalid, 1);
        checkOutput("alt2_pipe_rdata", pipe_rdata, 32'h50505050);
        checkOutput("alt2_dbg_rvalid", dbg_rvalid, 0);
        checkOutput("alt2_dbg_ack", dbg_ack, 1);
        checkOutput("alt2_mem_addr", mem_addr, 32'h060);
        applyStimulus(0, 1, 0, 10'h070, 0, 0, 0, 0, 0, 0, 32'h60606060);
        checkOutput("alt3_dbg_rvalid", dbg_rvalid, 1);
        checkOutput("alt3_dbg_rdata", dbg_rdata, 32'h60606060);
        checkOutput("alt3_pipe_rvalid", pipe_rvalid, 0);
        checkOutput("alt3_pipe_hold", pipe_rdata, 32'h50505050);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h70707070);
        checkOutput("alt4_pipe_rvalid", pipe_rvalid, 1);
        checkOutput("alt4_pipe_rdata", pipe_rdata, 32'h70707070);
        checkOutput("alt4_dbg_rvalid", dbg_rvalid, 0);
        checkOutput("alt4_dbg_hold", dbg_rdata, 32'h60606060);

        // Reset right after a pipe read grant kills the pending return.
        applyStimulus(0, 1, 0, 10'h080, 0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("pre_rst_en", mem_en, 1);
        applyStimulus(1, 1, 0, 10'h080, 0, 0, 0, 0, 0, 0, 32'h80808080);
        checkOutput("mid_rst_rvalid", pipe_rvalid, 0);
        checkOutput("mid_rst_pipe_rdata", pipe_rdata, 0);
        checkOutput("mid_rst_dbg_rdata", dbg_rdata, 0);
        checkOutput("mid_rst_mem_en", mem_en, 0);
        checkOutput("mid_rst_stall", pipe_stall, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80808080);
        checkOutput("post_rst_rvalid", pipe_rvalid, 0);
        checkOutput("post_rst_rdata", pipe_rdata, 0);

        $display("[TB] directed sequence complete");
        $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter D_SIZE, default 32, data word width.
REQ-002 Parameter ADDR_LINE_MEM, default 10, data-memory address width.
REQ-003 Parameter MAX_WAIT, default 4, range 1..15; maximum consecutive cycles a pending debug request is denied.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pipe_req  in  1  MEM stage requests one data-memory access this cycle.
REQ-007 pipe_we  in  1  1 = write (STW), 0 = read (LDW).
REQ-008 pipe_addr  in  ADDR_LINE_MEM  pipeline access address.
REQ-009 pipe_wdata  in  D_SIZE  pipeline write data.
REQ-010 pipe_stall  out  1  pipeline request not granted this cycle; MEM stage holds its inputs.
REQ-011 pipe_rvalid  out  1  pipe_rdata carries a pipeline read result.
REQ-012 pipe_rdata  out  D_SIZE  pipeline read data.
REQ-013 dbg_req  in  1  debug/loader port request, held until dbg_ack.
REQ-014 dbg_we, dbg_addr, dbg_wdata  in  1 / ADDR_LINE_MEM / D_SIZE  debug access fields, stable while dbg_req=1.
REQ-015 dbg_halt  in  1  level; debug port owns memory, pipeline frozen.
REQ-016 dbg_ack  out  1  one-cycle pulse: debug access issued this cycle.
REQ-017 dbg_rvalid, dbg_rdata  out  1 / D_SIZE  debug read result.
REQ-018 mem_en, mem_we, mem_addr, mem_wdata  out  1 / 1 / ADDR_LINE_MEM / D_SIZE  single data-memory port command.
REQ-019 mem_rdata  in  D_SIZE  memory read data, valid the cycle after mem_en=1 with mem_we=0.

Function
REQ-020 States NORMAL, FORCE, HALTED; at most one access issued per cycle (mem_en drives exactly the granted requester's fields).
REQ-021 Grant decode (mem_*, dbg_ack, pipe_stall) is combinational from current state and inputs.
REQ-022 NORMAL: pipe_req=1 -> pipe granted, pipe_stall=0; dbg granted only when pipe_req=0 and dbg_req=1.
REQ-023 wait_cnt (4 bit): in NORMAL, increments each cycle dbg_req=1 without grant; cleared on any dbg grant or when dbg_req=0.
REQ-024 NORMAL -> FORCE when an increment makes wait_cnt equal MAX_WAIT.
REQ-025 FORCE: dbg granted unconditionally if dbg_req=1, pipe_stall=pipe_req; next state NORMAL, wait_cnt cleared; if dbg_req=0 in FORCE, no access, return to NORMAL.
REQ-026 HALTED entered from any state when dbg_halt=1 (priority over FORCE transition); in HALTED, pipe_stall=pipe_req, dbg granted whenever dbg_req=1, wait_cnt held 0.
REQ-027 HALTED -> NORMAL the cycle after dbg_halt samples 0.
REQ-028 pipe_stall=0 whenever pipe_req=0.
REQ-029 Read return: owner tag registered at grant; next cycle asserts exactly one of pipe_rvalid/dbg_rvalid for one cycle, with matching rdata = mem_rdata (registered). Writes produce no rvalid.
REQ-030 pipe_rdata/dbg_rdata hold last value while rvalid=0.
REQ-031 Read returns are pipelined: a new grant is allowed in the same cycle a previous read returns; back-to-back reads give rvalid every cycle.

Reset
REQ-032 While reset=1: state NORMAL, wait_cnt=0, mem_en=0, dbg_ack=0, pipe_stall=0, pipe_rvalid=0, dbg_rvalid=0, pipe_rdata=0, dbg_rdata=0.
REQ-033 A read granted in the cycle before reset asserts returns no rvalid.
REQ-034 After reset deasserts, first grant possible in the first cycle with reset=0.

Verification (MAX_WAIT=4)
REQ-035 pipe_req=1, we=0, addr=0x010, mem_rdata=0xDEADBEEF next cycle -> mem_en=1, pipe_stall=0; next cycle pipe_rvalid=1, pipe_rdata=0xDEADBEEF.
REQ-036 pipe_req and dbg_req continuously high -> dbg denied 4 cycles, 5th cycle FORCE: dbg_ack=1, pipe_stall=1; following cycle pipe granted again.
REQ-037 dbg_halt=1 with pipe_req=1, dbg write addr=0x3FF data=0x12345678 -> pipe_stall=1 every halted cycle, mem_we=1 to 0x3FF, dbg_ack single pulse; dbg_halt=0 -> pipe resumes next cycle.
REQ-038 Alternating pipe read and dbg read on consecutive cycles -> rvalids alternate pipe/dbg one cycle later, data never crossed.
REQ-039 reset=1 asserted the cycle after a pipe read grant -> no pipe_rvalid, all outputs at reset values.
REQ-040 dbg_req dropped while in FORCE -> no memory access, state NORMAL next cycle, wait_cnt=0.
